// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer with req/ack handshake and pipeline stall
// One access per EX/MEM instruction: IDLE latches it, BUSY holds the request, DONE releases the pipeline.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              MemRd_i,
    input  logic              MemWr_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] WrData_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] RdData_o,
    output logic              err_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] busyCnt;
    logic             acc;
    logic             aligned;

    assign acc     = MemRd_i | MemWr_i;
    assign aligned = (Addr_i[1:0] == 2'b00);

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign stall_o = rst_n_i & (((state == IDLE) & acc) | (state == BUSY));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            busyCnt     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            RdData_o    <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (aligned) begin
                            mem_addr_o  <= Addr_i;
                            mem_wdata_o <= WrData_i;
                            mem_we_o    <= MemWr_i;
                            mem_req_o   <= 1'b1;
                            busyCnt     <= '0;
                            state       <= BUSY;
                        end else begin
                            err_o    <= 1'b1;
                            RdData_o <= '0;
                            state    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            RdData_o <= mem_rdata_i;
                        end
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (busyCnt == CNT_LAST) begin
                        // Abort: a lost store is reported only through err_o.
                        err_o     <= 1'b1;
                        RdData_o  <= '0;
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else begin
                        busyCnt <= busyCnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed table, reset corner cases and randomized transactions for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          MemRd_i, MemWr_i;
    logic [AW-1:0] Addr_i;
    logic [DW-1:0] WrData_i;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
    logic          stall_o;
    logic [DW-1:0] RdData_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .MemRd_i(MemRd_i), .MemWr_i(MemWr_i), .Addr_i(Addr_i), .WrData_i(WrData_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .RdData_o(RdData_o), .err_o(err_o)
    );

    int nCmp = 0;
    int nErr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;       // BUSY cycle (1-based) carrying ack; 0 = never
        logic [31:0] rdata;
        int          expStall;
        int          expReq;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                                input int es, input int er, input logic [31:0] erd, input logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.k = k; v.rdata = rdata;
        v.expStall = es; v.expReq = er; v.expRd = erd; v.expErr = ee;
        return v;
    endfunction

    // Entered at posedge+1 with the DUT in IDLE; leaves at posedge+1 after the DONE edge.
    task automatic run_txn(input vec_t v, input bit noise, input string tag);
        int  stallCnt = 0;
        int  reqCnt = 0;
        bit  done = 0;
        MemRd_i = v.rd; MemWr_i = v.wr; Addr_i = v.addr; WrData_i = v.wdata;
        mem_ack_i = 1'b0;
        for (int c = 0; c < TO + 10 && !done; c++) begin
            #1;
            if (!stall_o) begin
                done = 1;
            end else begin
                stallCnt++;
                if (mem_req_o) begin
                    reqCnt++;
                    chk({tag, " addr"}, 64'(mem_addr_o), 64'(v.addr));
                    chk({tag, " we"}, 64'(mem_we_o), 64'(v.wr));
                    chk({tag, " wdata"}, 64'(mem_wdata_o), 64'(v.wdata));
                end
                if (mem_req_o && reqCnt == v.k) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = v.rdata;
                end else begin
                    mem_ack_i = (noise && !mem_req_o) ? 1'($urandom_range(0, 1)) : 1'b0;
                    mem_rdata_i = $urandom;
                end
                @(posedge clk_i); #1;
                mem_ack_i = 1'b0;
            end
        end
        if (!done) begin
            chk({tag, " reached DONE"}, 64'd0, 64'd1);
        end else begin
            chk({tag, " req in DONE"}, 64'(mem_req_o), 64'd0);
            chk({tag, " stall cycles"}, 64'(stallCnt), 64'(v.expStall));
            chk({tag, " req cycles"}, 64'(reqCnt), 64'(v.expReq));
            chk({tag, " RdData"}, 64'(RdData_o), 64'(v.expRd));
            chk({tag, " err"}, 64'(err_o), 64'(v.expErr));
            mem_ack_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata_i = $urandom;
        end
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        MemRd_i = 1'b0; MemWr_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input bit noise);
        MemRd_i = 1'b0; MemWr_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            Addr_i = $urandom;
            #1;
            chk("idle stall", 64'(stall_o), 64'd0);
            chk("idle req", 64'(mem_req_o), 64'd0);
            mem_ack_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata_i = $urandom;
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
        end
    endtask

    vec_t        tbl[10];
    vec_t        v;
    logic [31:0] lastRd;
    logic        errModel;
    logic [31:0] rnd;
    logic [1:0]  sel;
    int          r;
    bit          timedOut;

    initial begin
        rst_n_i = 1'b0;
        MemRd_i = 1'b0; MemWr_i = 1'b0; Addr_i = '0; WrData_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;

        tbl[0] = mk(1, 0, 32'h10, 32'h0,        1, 32'hCAFEF00D, 2, 1, 32'hCAFEF00D, 0);
        tbl[1] = mk(0, 1, 32'h20, 32'h12345678, 3, 32'hDEADDEAD, 4, 3, 32'hCAFEF00D, 0);
        tbl[2] = mk(1, 0, 32'h40, 32'h0,        2, 32'h11112222, 3, 2, 32'h11112222, 0);
        tbl[3] = mk(1, 1, 32'h44, 32'h55AA55AA, 1, 32'h99999999, 2, 1, 32'h11112222, 0);
        tbl[4] = mk(1, 0, 32'h13, 32'h0,        1, 32'h77777777, 1, 0, 32'h0,        1);
        tbl[5] = mk(1, 0, 32'h50, 32'h0,        1, 32'hA5A5A5A5, 2, 1, 32'hA5A5A5A5, 1);
        tbl[6] = mk(1, 0, 32'h80, 32'h0,        0, 32'h0,        9, 8, 32'h0,        1);
        tbl[7] = mk(1, 0, 32'h84, 32'h0,        8, 32'h0F0F0F0F, 9, 8, 32'h0F0F0F0F, 1);
        tbl[8] = mk(0, 1, 32'h88, 32'h1,        0, 32'h0,        9, 8, 32'h0,        1);
        tbl[9] = mk(0, 1, 32'h8E, 32'h2,        1, 32'h0,        1, 0, 32'h0,        1);

        @(posedge clk_i); @(posedge clk_i); #1;
        chk("reset req", 64'(mem_req_o), 64'd0);
        chk("reset we", 64'(mem_we_o), 64'd0);
        chk("reset addr", 64'(mem_addr_o), 64'd0);
        chk("reset wdata", 64'(mem_wdata_o), 64'd0);
        chk("reset RdData", 64'(RdData_o), 64'd0);
        chk("reset err", 64'(err_o), 64'd0);
        chk("reset stall", 64'(stall_o), 64'd0);
        rst_n_i = 1'b1;
        idle_cycles(2, 0);

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], 0, $sformatf("vec%0d", i));
        end
        idle_cycles(2, 0);

        // Reset between edges while a load sits in BUSY.
        MemRd_i = 1'b1; Addr_i = 32'h60;
        @(posedge clk_i); @(posedge clk_i); @(posedge clk_i); #3;
        chk("midreset req before", 64'(mem_req_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        chk("midreset req", 64'(mem_req_o), 64'd0);
        chk("midreset stall", 64'(stall_o), 64'd0);
        chk("midreset err", 64'(err_o), 64'd0);
        chk("midreset RdData", 64'(RdData_o), 64'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        run_txn(mk(1, 0, 32'h60, 32'h0, 2, 32'h0BADBEEF, 3, 2, 32'h0BADBEEF, 0), 0, "postreset");

        lastRd = 32'h0BADBEEF;
        errModel = 1'b0;
        for (int t = 0; t < 60; t++) begin
            sel = 2'($urandom_range(1, 3));
            v.rd = sel[0];
            v.wr = sel[1];
            rnd = $urandom;
            v.addr = {rnd[31:2], 2'b00};
            if ($urandom_range(0, 5) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
            v.wdata = $urandom;
            v.rdata = $urandom;
            r = $urandom_range(0, 9);
            v.k = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 4);

            if (v.addr[1:0] != 2'b00) begin
                v.expStall = 1; v.expReq = 0; lastRd = '0; errModel = 1'b1;
            end else begin
                timedOut = (v.k < 1) || (v.k > TO);
                v.expReq = timedOut ? TO : v.k;
                v.expStall = 1 + v.expReq;
                if (timedOut) begin
                    lastRd = '0;
                    errModel = 1'b1;
                end else if (!v.wr) begin
                    lastRd = v.rdata;
                end
            end
            v.expRd = lastRd;
            v.expErr = errModel;
            run_txn(v, 1, $sformatf("rnd%0d", t));
            idle_cycles($urandom_range(0, 2), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
